// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared definitions for the SPI bus scheduler.
//   - requester indices (flash, SD, expansion port) and requester count
//   - scheduler FSM state encoding
//   - round-robin pointer increment helper
package spi_sched_pkg;

    localparam int NREQ      = 3;
    localparam int REQ_FLASH = 0;
    localparam int REQ_SD    = 1;
    localparam int REQ_EXT   = 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_READY   = 3'd2;
    localparam logic [2:0] ST_SHIFT   = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;

    // Next requester index in round-robin order (0 -> 1 -> 2 -> 0).
    function automatic logic [1:0] rr_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: one-byte SPI mode 0 master engine, MSB first.
//   clk, rst   : clock, synchronous active-high reset
//   start, din : load din and begin shifting (ignored fields otherwise)
//   miso       : serial input, sampled on each SCLK rising edge
//   sclk, mosi : serial clock (idle 0) and output (idle 1)
//   dout, done : received byte, updated together with a one-cycle done pulse
//                at the eighth SCLK falling edge
module spi_byte_shifter
    import spi_sched_pkg::*;
#(
    parameter int CLKDIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] dout,
    output logic       done
);

    localparam logic [3:0] DIV_LAST = 4'(CLKDIV - 1);

    logic       active_q, active_d;
    logic [3:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic       sclk_q, sclk_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] dout_q, dout_d;
    logic       done_q, done_d;

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        if (start) begin
            active_d = 1'b1;
            div_d    = '0;
            bit_d    = '0;
            sclk_d   = 1'b0;
            tx_d     = din;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], miso};
                end else begin
                    // Falling edge: present the next bit; ones fill so MOSI
                    // idles high once the byte is out.
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[6:0], 1'b1};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        active_d = 1'b0;
                        done_d   = 1'b1;
                        dout_d   = rx_q;
                    end
                end
            end else begin
                div_d = div_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b0;
            tx_q     <= 8'hFF;
            rx_q     <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
        end
    end

    assign sclk = sclk_q;
    assign mosi = tx_q[7];
    assign dout = dout_q;
    assign done = done_q;

endmodule

// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler: shares one SPI byte engine between flash (0), SD (1) and
// the 16-CS expansion port (2). Round-robin grant held for a whole CS
// transaction, CS setup, byte shifting, CS release gap, and pin routing.
//   clk, rst                 : clock, synchronous active-high reset
//   req, ext_sel, gnt        : per-requester request, ext CS index, grant
//   tx_valid, tx_data, tx_ready : byte start handshake (byte n at [8n+7:8n])
//   rx_valid, rx_data        : received byte pulse / shared data
//   flash_*, sd_*, ext_*     : physical device pins
//   activity                 : high while any CS is low
module spi_bus_scheduler
    import spi_sched_pkg::*;
#(
    parameter int CLKDIV = 2,
    parameter int CS_GAP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [3:0]      ext_sel,
    output logic [NREQ-1:0] gnt,
    input  logic [NREQ-1:0] tx_valid,
    input  logic [23:0]     tx_data,
    output logic [NREQ-1:0] tx_ready,
    output logic [NREQ-1:0] rx_valid,
    output logic [7:0]      rx_data,
    output logic            flash_cs_n,
    output logic            flash_clk,
    output logic            flash_di,
    input  logic            flash_do,
    output logic            sd_cs_n,
    output logic            sd_clk,
    output logic            sd_mosi,
    input  logic            sd_miso,
    output logic [15:0]     ext_cs,
    output logic            ext_clk,
    output logic            ext_di,
    input  logic            ext_do,
    output logic            activity
);

    localparam logic [7:0] SETUP_LAST = 8'(CLKDIV - 1);
    localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

    logic [2:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      g_q, g_d;
    logic [1:0]      rr_q, rr_d;
    logic [3:0]      ext_idx_q, ext_idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            flash_cs_n_q, flash_cs_n_d;
    logic            sd_cs_n_q, sd_cs_n_d;
    logic [15:0]     ext_cs_q, ext_cs_d;
    logic            activity_q, activity_d;

    logic            win_found;
    logic [1:0]      win_idx;
    logic [1:0]      cand;
    logic            sh_start;
    logic [7:0]      sh_din;
    logic            sh_miso;
    logic            sh_sclk;
    logic            sh_mosi;
    logic [7:0]      sh_dout;
    logic            sh_done;
    logic            cs_on;

    // Round-robin search starting at rr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = rr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = rr_inc(cand);
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        g_d       = g_q;
        rr_d      = rr_q;
        ext_idx_d = ext_idx_q;
        cnt_d     = cnt_q;
        sh_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_d   = NREQ'(1) << win_idx;
                    g_d     = win_idx;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                    if (win_idx == 2'(REQ_EXT)) ext_idx_d = ext_sel;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = ST_READY;
                else                     cnt_d   = cnt_q + 8'd1;
            end
            ST_READY: begin
                // A byte strobe beats a same-cycle request drop.
                if (tx_valid[g_q]) begin
                    sh_start = 1'b1;
                    state_d  = ST_SHIFT;
                end else if (!req[g_q]) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_SHIFT: begin
                if (sh_done) state_d = ST_READY;
            end
            ST_RELEASE: begin
                gnt_d   = '0;
                rr_d    = rr_inc(g_q);
                cnt_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) state_d = ST_IDLE;
                else                   cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CS pins are flops computed from the next state so they change exactly
    // on the state boundary, with activity registered alongside them.
    always_comb begin
        cs_on        = (state_d == ST_SETUP) || (state_d == ST_READY) ||
                       (state_d == ST_SHIFT);
        flash_cs_n_d = !(cs_on && gnt_d[REQ_FLASH]);
        sd_cs_n_d    = !(cs_on && gnt_d[REQ_SD]);
        ext_cs_d     = (cs_on && gnt_d[REQ_EXT]) ? ~(16'h0001 << ext_idx_d) : 16'hFFFF;
        activity_d   = !flash_cs_n_d || !sd_cs_n_d || (ext_cs_d != 16'hFFFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            g_q          <= '0;
            rr_q         <= 2'(REQ_FLASH);
            ext_idx_q    <= '0;
            cnt_q        <= '0;
            flash_cs_n_q <= 1'b1;
            sd_cs_n_q    <= 1'b1;
            ext_cs_q     <= 16'hFFFF;
            activity_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            g_q          <= g_d;
            rr_q         <= rr_d;
            ext_idx_q    <= ext_idx_d;
            cnt_q        <= cnt_d;
            flash_cs_n_q <= flash_cs_n_d;
            sd_cs_n_q    <= sd_cs_n_d;
            ext_cs_q     <= ext_cs_d;
            activity_q   <= activity_d;
        end
    end

    always_comb begin
        case (g_q)
            2'd1:    sh_din = tx_data[15:8];
            2'd2:    sh_din = tx_data[23:16];
            default: sh_din = tx_data[7:0];
        endcase
    end

    assign sh_miso = gnt_q[REQ_FLASH] ? flash_do :
                     gnt_q[REQ_SD]    ? sd_miso  :
                     gnt_q[REQ_EXT]   ? ext_do   : 1'b1;

    spi_byte_shifter #(.CLKDIV(CLKDIV)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .start (sh_start),
        .din   (sh_din),
        .miso  (sh_miso),
        .sclk  (sh_sclk),
        .mosi  (sh_mosi),
        .dout  (sh_dout),
        .done  (sh_done)
    );

    assign gnt      = gnt_q;
    assign tx_ready = (state_q == ST_READY) ? gnt_q : '0;
    assign rx_valid = (state_q == ST_SHIFT && sh_done) ? gnt_q : '0;
    assign rx_data  = sh_dout;

    // Only the granted device sees the engine; others idle at clk 0 / MOSI 1.
    assign flash_cs_n = flash_cs_n_q;
    assign flash_clk  = gnt_q[REQ_FLASH] & sh_sclk;
    assign flash_di   = gnt_q[REQ_FLASH] ? sh_mosi : 1'b1;
    assign sd_cs_n    = sd_cs_n_q;
    assign sd_clk     = gnt_q[REQ_SD] & sh_sclk;
    assign sd_mosi    = gnt_q[REQ_SD] ? sh_mosi : 1'b1;
    assign ext_cs     = ext_cs_q;
    assign ext_clk    = gnt_q[REQ_EXT] & sh_sclk;
    assign ext_di     = gnt_q[REQ_EXT] ? sh_mosi : 1'b1;
    assign activity   = activity_q;

endmodule

// File: tb/tb_spi_bus_scheduler.sv
module tb_spi_bus_scheduler;

    localparam int CLKDIV = 2;
    localparam int CS_GAP = 4;
    localparam int TMO    = 400;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [3:0]  ext_sel;
    logic [2:0]  gnt;
    logic [2:0]  tx_valid;
    logic [23:0] tx_data;
    logic [2:0]  tx_ready;
    logic [2:0]  rx_valid;
    logic [7:0]  rx_data;
    logic        flash_cs_n, flash_clk, flash_di, flash_do;
    logic        sd_cs_n, sd_clk, sd_mosi, sd_miso;
    logic [15:0] ext_cs;
    logic        ext_clk, ext_di, ext_do;
    logic        activity;

    always #5 clk = ~clk;

    spi_bus_scheduler #(.CLKDIV(CLKDIV), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst(rst), .req(req), .ext_sel(ext_sel), .gnt(gnt),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .flash_cs_n(flash_cs_n), .flash_clk(flash_clk), .flash_di(flash_di), .flash_do(flash_do),
        .sd_cs_n(sd_cs_n), .sd_clk(sd_clk), .sd_mosi(sd_mosi), .sd_miso(sd_miso),
        .ext_cs(ext_cs), .ext_clk(ext_clk), .ext_di(ext_di), .ext_do(ext_do),
        .activity(activity)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- SPI slave models (one per physical device) ----------
    logic [2:0] dclk, dmosi, dcs_n;
    logic [2:0] pclk = 3'b000;
    logic [2:0] pcs_n = 3'b111;
    logic [7:0] cap[3]   = '{8'h00, 8'h00, 8'h00};
    int         rises[3] = '{0, 0, 0};
    logic [2:0] fall[3]  = '{3'd0, 3'd0, 3'd0};
    logic [7:0] resp[3]  = '{8'h00, 8'h00, 8'h00};
    logic       any_low;

    assign dclk    = {ext_clk, sd_clk, flash_clk};
    assign dmosi   = {ext_di, sd_mosi, flash_di};
    assign dcs_n   = {&ext_cs, sd_cs_n, flash_cs_n};
    assign any_low = ~&dcs_n;

    // Mode 0 slave: MSB out when CS falls, next bit after each SCLK fall.
    assign flash_do = resp[0][3'd7 - fall[0]];
    assign sd_miso  = resp[1][3'd7 - fall[1]];
    assign ext_do   = resp[2][3'd7 - fall[2]];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (pcs_n[d] === 1'b1 && dcs_n[d] === 1'b0) fall[d] <= 3'd0;
            else if (pclk[d] === 1'b1 && dclk[d] === 1'b0) fall[d] <= fall[d] + 3'd1;
            if (pclk[d] === 1'b0 && dclk[d] === 1'b1) begin
                cap[d]   <= {cap[d][6:0], dmosi[d]};
                rises[d] <= rises[d] + 1;
            end
        end
        pclk  <= dclk;
        pcs_n <= dcs_n;
    end

    // ---------------- continuous pin monitor ------------------------------
    logic        mon_en   = 1'b0;
    logic        in_txn   = 1'b0;
    int          cur_g    = 0;
    logic [15:0] exp_ext  = 16'hFFFF;
    int          gap_cnt  = 0;
    logic        seen_low = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            seen_low <= 1'b0;
            gap_cnt  <= 0;
        end else if (mon_en) begin
            chk("activity", 32'(activity), 32'(any_low));
            for (int d = 0; d < 3; d++)
                if (!gnt[d]) chk($sformatf("idle_pins%0d", d), 32'({dclk[d], dmosi[d], dcs_n[d]}), 32'(3'b011));
            if (in_txn) begin
                chk("cs_hold", 32'(dcs_n[cur_g]), 32'd0);
                if (cur_g == 2) chk("ext_cs", 32'(ext_cs), 32'(exp_ext));
            end
            if (any_low) begin
                if (seen_low && gap_cnt > 0) chk("cs_gap", 32'(gap_cnt >= CS_GAP), 32'd1);
                seen_low <= 1'b1;
                gap_cnt  <= 0;
            end else if (seen_low) begin
                gap_cnt <= gap_cnt + 1;
            end
        end
    end

    // ---------------- reference arbitration model -------------------------
    int rr_m = 0;

    function automatic int model_win(input int rr, input logic [2:0] pend);
        for (int i = 0; i < 3; i++)
            if (pend[(rr + i) % 3]) return (rr + i) % 3;
        return 0;
    endfunction

    task automatic take(input logic [2:0] pend, output int g, output bit ok);
        int n = 0;
        int w;
        while (gnt == 3'b000 && n < TMO) begin tick(); n++; end
        chk("grant_wait", 32'(n < TMO), 32'd1);
        ok = (n < TMO);
        w  = model_win(rr_m, pend);
        g  = w;
        if (ok) begin
            chk("grant", 32'(gnt), 32'(1 << w));
            cur_g = g;
            if (g == 2) begin
                exp_ext = ~(16'h0001 << ext_sel);
                ext_sel = 4'($urandom);   // must have been latched at grant
            end
            in_txn = 1'b1;
        end
    endtask

    task automatic serve(input int g, input byte_q_t tq, input byte_q_t rq, input bit drop);
        int n, lat, r0, dropat;
        for (int b = 0; b < tq.size(); b++) begin
            n = 0;
            while (!tx_ready[g] && n < TMO) begin tick(); n++; end
            chk("ready_wait", 32'(n < TMO), 32'd1);
            chk("tx_ready", 32'(tx_ready), 32'(1 << g));
            resp[g]  = rq[b];
            tx_data  = 24'($urandom);
            tx_data[8*g +: 8] = tq[b];
            tx_valid = 3'(1 << g) | 3'($urandom);
            r0 = rises[g];
            tick();
            tx_valid = 3'b000;
            chk("ready_fall", 32'(tx_ready[g]), 32'd0);
            chk("mosi_bit7", 32'(dmosi[g]), 32'(tq[b][7]));
            dropat = (drop && b == tq.size() - 1) ? $urandom_range(1, 16*CLKDIV - 1) : -1;
            lat = 0;
            while (!rx_valid[g] && lat < TMO) begin
                tick(); lat++;
                if (lat == dropat) begin req[g] = 1'b0; in_txn = 1'b0; end
            end
            chk("byte_latency", 32'(lat), 32'(16*CLKDIV));
            chk("rx_valid", 32'(rx_valid), 32'(1 << g));
            chk("rx_data", 32'(rx_data), 32'(rq[b]));
            chk("mosi_stream", 32'(cap[g]), 32'(tq[b]));
            chk("sclk_pulses", 32'(rises[g] - r0), 32'd8);
            tick();
            chk("rx_pulse_end", 32'(rx_valid), 32'd0);
            chk("ready_again", 32'(tx_ready[g]), 32'd1);
        end
        if (!drop) begin req[g] = 1'b0; in_txn = 1'b0; end
        n = 0;
        while (gnt != 3'b000 && n < TMO) begin
            tick(); n++;
            if (rx_valid != 3'b000) chk("spurious_rx", 32'(rx_valid), 32'd0);
        end
        chk("release", 32'(n < TMO), 32'd1);
        rr_m = (g + 1) % 3;
    endtask

    task automatic round(input logic [2:0] mask);
        logic [2:0] pend = mask;
        int g;
        bit ok;
        byte_q_t tq, rq;
        ext_sel = 4'($urandom);
        req     = req | mask;
        while (pend != 3'b000) begin
            take(pend, g, ok);
            if (!ok) begin req = 3'b000; in_txn = 1'b0; return; end
            tq = {}; rq = {};
            for (int i = 0; i < $urandom_range(1, 3); i++) begin
                tq.push_back(8'($urandom));
                rq.push_back(8'($urandom));
            end
            serve(g, tq, rq, $urandom_range(0, 3) == 0);
            pend[g] = 1'b0;
        end
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_rdy"}, 32'(tx_ready), 32'd0);
        chk({tag, "_rxv"}, 32'(rx_valid), 32'd0);
        chk({tag, "_cs"}, 32'({flash_cs_n, sd_cs_n, ext_cs}), 32'h3FFFF);
        chk({tag, "_clk"}, 32'({flash_clk, sd_clk, ext_clk}), 32'd0);
        chk({tag, "_mosi"}, 32'({flash_di, sd_mosi, ext_di}), 32'd7);
        chk({tag, "_act"}, 32'(activity), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bit ok;
        int rxseen;
        byte_q_t tq, rq;
        rst = 1'b1; req = '0; ext_sel = '0; tx_valid = '0; tx_data = '0;
        repeat (3) tick();
        check_reset_pins("reset");
        chk("reset_rxdata", 32'(rx_data), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) tick();

        // Single flash transaction: 0x9F out, 0xEF back.
        req[0] = 1'b1;
        take(3'b001, g, ok);
        tq = {8'h9F}; rq = {8'hEF};
        if (ok) serve(g, tq, rq, 1'b0);

        // Expansion port, chip select 5.
        ext_sel = 4'd5; req[2] = 1'b1;
        take(3'b100, g, ok);
        chk("ext_sel5_cs", 32'(ext_cs), 32'hFFDF);
        tq = {8'hA5}; rq = {8'h3C};
        if (ok) serve(g, tq, rq, 1'b0);

        // SD back-to-back bytes, CS held low throughout.
        req[1] = 1'b1;
        take(3'b010, g, ok);
        tq = {8'hFF, 8'h40}; rq = {8'h01, 8'hC3};
        if (ok) serve(g, tq, rq, 1'b0);

        // SD request dropped mid-byte: byte completes, then release.
        req[1] = 1'b1;
        take(3'b010, g, ok);
        tq = {8'h5A}; rq = {8'h96};
        if (ok) serve(g, tq, rq, 1'b1);

        // All three request together; round-robin continues from the pointer.
        round(3'b111);
        round(3'b111);

        for (int r = 0; r < 12; r++) begin
            round(3'($urandom_range(1, 7)));
            repeat ($urandom_range(0, 6)) tick();
        end

        // Reset in the middle of a byte.
        g = $urandom_range(0, 2);
        ext_sel = 4'($urandom);
        req[g] = 1'b1;
        take(3'(1 << g), g, ok);
        if (ok) begin
            int n = 0;
            while (!tx_ready[g] && n < TMO) begin tick(); n++; end
            tx_data  = 24'($urandom);
            tx_valid = 3'(1 << g);
            tick();
            tx_valid = 3'b000;
            repeat ($urandom_range(3, 20)) tick();
        end
        rst = 1'b1; req = 3'b000; in_txn = 1'b0;
        tick();
        check_reset_pins("midrst");
        tick();
        rst = 1'b0;
        rr_m = 0;
        rxseen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rx_valid != 3'b000) rxseen++;
        end
        chk("midrst_no_rx", 32'(rxseen), 32'd0);
        round(3'b111);

        repeat (10) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_bus_scheduler.md
Name: spi_bus_scheduler

Overview:
- Shares one SPI byte-shift engine between three requesters: 0 = flash boot/loader, 1 = SD interface, 2 = expansion port (16 chip selects).
- Grants the bus round-robin and holds the grant for a whole chip-select transaction. Sequences CS setup, byte shifting in SPI mode 0, and a CS release gap.
- Routes clock, MOSI and MISO to the selected physical device only. Sits between the ZX-Uno SPI port logic and the flash, SD and ext pins at top level.

Parameters:
- CLKDIV, 2: SCLK half-period in clk cycles (1..15). One byte takes 16*CLKDIV cycles.
- CS_GAP, 4: clk cycles with all CS high between two transactions (>=1).

Ports:
- clk, in, 1: system clock (28 MHz domain).
- rst, in, 1: synchronous reset, active-high.
- req, in, 3: per-requester bus request; held high for the whole transaction.
- ext_sel, in, 4: ext_cs index for requester 2; sampled at grant.
- gnt, out, 3: one-hot grant.
- tx_valid, in, 3: per-requester byte-start strobe.
- tx_data, in, 24: bytes packed, requester n at [8n+7:8n].
- tx_ready, out, 3: granted requester may strobe tx_valid.
- rx_valid, out, 3: one-cycle pulse, received byte available.
- rx_data, out, 8: last received byte (shared).
- flash_cs_n, flash_clk, flash_di, out, 1 each: flash pins.
- flash_do, in, 1: flash MISO.
- sd_cs_n, sd_clk, sd_mosi, out, 1 each: SD pins.
- sd_miso, in, 1: SD MISO.
- ext_cs, out, 16: expansion chip selects, active low.
- ext_clk, ext_di, out, 1 each: expansion clock and MOSI.
- ext_do, in, 1: expansion MISO.
- activity, out, 1: high while any CS is low (drives testled).

Behaviour:
- Reset values, applied in the cycle after rst is high: gnt=0, tx_ready=0, rx_valid=0, rx_data=0, all CS high (ext_cs=16'hFFFF), all clocks 0, all MOSI 1, activity 0, RR pointer = requester 0 highest priority. Reset mid-byte aborts immediately; no rx_valid is produced.
- IDLE
  - If any req is high, grant the highest-priority requester in RR order. Priority starts at the requester after the last one granted.
  - Set gnt one-hot and latch ext_sel if the winner is 2. Go to SETUP.
- SETUP
  - Selected CS goes low in the first SETUP cycle.
  - Wait CLKDIV cycles, then go to READY.
- READY
  - tx_ready[g]=1 for the granted requester only.
  - tx_valid[g] with tx_ready: latch the byte, tx_ready falls the next cycle, go to SHIFT.
  - Same-cycle priority: tx_valid wins over req[g] falling.
  - req[g] low with no tx_valid: go to RELEASE.
  - tx_valid from a non-granted requester is ignored.
- SHIFT (mode 0, MSB first)
  - MOSI carries bit 7 on SHIFT entry.
  - SCLK rises after CLKDIV cycles; MISO is sampled on each rising edge.
  - SCLK falls CLKDIV cycles later and the next bit is presented.
  - After 8 falling edges, pulse rx_valid[g] with rx_data updated in the same cycle, and return to READY. tx_ready is high on the following cycle, so back-to-back bytes are allowed.
  - If req drops during SHIFT, the byte completes; the READY visit then exits to RELEASE.
- RELEASE: deassert CS, clear gnt, advance the RR pointer past g, go to GAP.
- GAP: CS_GAP cycles all high, then go to IDLE. Requests raised during GAP wait.
- Routing: only the granted device sees toggling clock and MOSI. Non-selected clocks stay 0 and non-selected MOSI lines stay 1. MISO is muxed by grant (ext_do for any ext index).
- activity = ~flash_cs_n | ~sd_cs_n | (ext_cs != 16'hFFFF), registered.

Decomposition:
- Package spi_sched_pkg:
  - requester indices REQ_FLASH=0, REQ_SD=1, REQ_EXT=2;
  - state encoding (IDLE, SETUP, READY, SHIFT, RELEASE, GAP);
  - NREQ=3.
- Sub-module spi_byte_shifter:
  - ports clk, rst, start, din[7:0], miso, sclk, mosi, dout[7:0], done;
  - owns the CLKDIV divider and bit counter.
- The scheduler keeps the arbiter, FSM and pin routing.

Test Plan:
- Single flash transaction: req[0]=1, tx_data byte 0x9F, flash_do tied to a model returning 0xEF -> flash_cs_n low for the whole transaction, 8 flash_clk pulses (byte lasts 32 cycles at CLKDIV=2), rx_valid[0] pulse with rx_data=0xEF; sd_clk and ext_clk stay 0.
- Simultaneous req=3'b111 after reset -> grants in order 0,1,2, each separated by >=4 cycles of all-CS-high; next round restarts at 0.
- Ext select: req[2] with ext_sel=5, byte 0xA5 -> ext_cs=16'hFFDF during the transaction; ext_di bit stream 1,0,1,0,0,1,0,1.
- Back-to-back: SD sends 0xFF, 0x40 with tx_valid on the first tx_ready cycle -> sd_cs_n stays low throughout, two rx_valid pulses, no CS glitch.
- req[1] dropped mid-byte -> byte completes, rx_valid[1] fires, then CS high and gnt=0.
- rst during SHIFT -> the next cycle shows all CS high, clocks 0, no rx_valid; a new grant after reset starts at requester 0.
